axil_led_regs: RTL and testbench

AXI4-Lite slave register block that receives the LED pattern writes issued by the upstream traffic generator's AXI4-Lite master. It sits on the system interconnect at the generator's target address. It drives a 4-bit LED output and counts accepted writes. It also provides a scratch register and a read-only ID register for bring-up checks over the chip-to-chip link.

---
 rtl/axil_pkg.sv | 29 ++
 rtl/axil_byte_merge.sv | 24 ++
 rtl/axil_led_regs.sv | 209 ++++++++++++++++++++
 tb/tb_axil_led_regs.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite LED register block: response codes,
// register word offsets and the write/read channel state encodings.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word offsets, i.e. ADDR[3:2]
    localparam logic [1:0] REG_LED     = 2'd0;
    localparam logic [1:0] REG_WRCOUNT = 2'd1;
    localparam logic [1:0] REG_SCRATCH = 2'd2;
    localparam logic [1:0] REG_ID      = 2'd3;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Only LED and SCRATCH accept writes; the other offsets answer SLVERR.
    function automatic logic reg_writable(input logic [1:0] off);
        return (off == REG_LED) || (off == REG_SCRATCH);
    endfunction

endpackage

// File: rtl/axil_byte_merge.sv
// Byte-strobe merge: each bit takes the new value when the strobe of its
// byte lane is set, otherwise keeps the old value. Works for widths that
// are not a multiple of 8 (a partial top lane uses its own strobe bit).
module axil_byte_merge #(
    parameter int WIDTH      = 32,
    parameter int STRB_WIDTH = (WIDTH + 7) / 8
) (
    input  logic [WIDTH-1:0]      old_word,
    input  logic [WIDTH-1:0]      new_word,
    input  logic [STRB_WIDTH-1:0] strb,
    output logic [WIDTH-1:0]      merged
);

    // Per-bit select driven by the strobe of the owning byte lane
    always_comb begin
        merged = old_word;
        for (int i = 0; i < WIDTH; i++) begin
            if (strb[i / 8]) begin
                merged[i] = new_word[i];
            end
        end
    end

endmodule

// File: rtl/axil_led_regs.sv
// AXI4-Lite slave holding the LED pattern, a write counter, a scratch word
// and a read-only ID. Write and read channels run independent FSMs.
//
// state  | meaning
// W_IDLE | collecting AW and W beats (either order); commits when both are in
// W_RESP | BVALID held with BRESP until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID held with RDATA/RRESP until RREADY
module axil_led_regs
    import axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          LED_WIDTH  = 4,
    parameter logic [31:0] BLOCK_ID   = 32'h1ED0_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    input  logic [2:0]            S_AXI_AWPROT,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic                  S_AXI_WVALID,
    input  logic [3:0]            S_AXI_WSTRB,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    input  logic [2:0]            S_AXI_ARPROT,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic                  S_AXI_RVALID,
    output logic [1:0]            S_AXI_RRESP,
    input  logic                  S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]  leds
);

    localparam int LED_STRB = (LED_WIDTH + 7) / 8;

    wstate_t               wstate;
    rstate_t               rstate;

    logic                  aw_done;
    logic                  w_done;
    logic [1:0]            aw_off_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;

    logic [LED_WIDTH-1:0]  led_q;
    logic [31:0]           wr_count;
    logic [DATA_WIDTH-1:0] scratch_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic [1:0]            wr_off;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic [LED_WIDTH-1:0]  led_merged;
    logic [DATA_WIDTH-1:0] scratch_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    // Protection bits and undecoded address bits carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};

    // A beat handshaking this very cycle counts as present, so the commit
    // lands on the same edge as the later of the two handshakes and BVALID
    // appears one cycle after it.
    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign commit  = (wstate == W_IDLE) & (aw_done | aw_hs) & (w_done | w_hs);
    assign wr_off  = aw_done ? aw_off_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_done ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_done ? w_strb_q : S_AXI_WSTRB;

    axil_byte_merge #(.WIDTH(LED_WIDTH)) u_led_merge (
        .old_word (led_q),
        .new_word (wr_data[LED_WIDTH-1:0]),
        .strb     (wr_strb[LED_STRB-1:0]),
        .merged   (led_merged)
    );

    axil_byte_merge #(.WIDTH(DATA_WIDTH)) u_scratch_merge (
        .old_word (scratch_q),
        .new_word (wr_data),
        .strb     (wr_strb),
        .merged   (scratch_merged)
    );

    // Write channel FSM: latch AW/W independently, then respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_off_q      <= 2'd0;
            w_data_q      <= '0;
            w_strb_q      <= 4'd0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_off_q      <= S_AXI_AWADDR[3:2];
                        aw_done       <= 1'b1;
                        S_AXI_AWREADY <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data_q     <= S_AXI_WDATA;
                        w_strb_q     <= S_AXI_WSTRB;
                        w_done       <= 1'b1;
                        S_AXI_WREADY <= 1'b0;
                    end
                    if (commit) begin
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= reg_writable(wr_off) ? RESP_OKAY : RESP_SLVERR;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        wstate        <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Register file update on write commit; WRCOUNT counts every OKAY LED write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            wr_count  <= 32'd0;
            scratch_q <= '0;
        end else if (commit) begin
            case (wr_off)
                REG_LED: begin
                    led_q    <= led_merged;
                    wr_count <= wr_count + 32'd1;
                end
                REG_SCRATCH: scratch_q <= scratch_merged;
                default: ;
            endcase
        end
    end

    assign leds = led_q;

    // Read mux over current register contents (pre-write on a commit cycle)
    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[3:2])
            REG_LED:     rd_word[LED_WIDTH-1:0] = led_q;
            REG_WRCOUNT: rd_word = wr_count;
            REG_SCRATCH: rd_word = scratch_q;
            REG_ID:      rd_word = BLOCK_ID;
            default:     rd_word = '0;
        endcase
    end

    // Read channel FSM: capture data on AR handshake, hold until RREADY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        S_AXI_RDATA   <= rd_word;
                        S_AXI_RRESP   <= RESP_OKAY;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        rstate        <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_led_regs.sv
// Randomized bench for axil_led_regs against a register-map model.
module tb_axil_led_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [2:0]  awprot;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic [3:0]  wstrb;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arprot;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic [1:0]  rresp;
    logic        rready;
    logic [3:0]  leds;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]  m_led;
    logic [31:0] m_count;
    logic [31:0] m_scratch;

    always #5 clk = ~clk;

    axil_led_regs dut (
        .clk           (clk),
        .reset         (reset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RREADY  (rready),
        .leds          (leds)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_led     = 4'h0;
        m_count   = 32'd0;
        m_scratch = 32'd0;
    endfunction

    // Applies a write to the model and returns the response it should get
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int off;
        off = int'(addr[3:2]);
        if (off == 0) begin
            if (strb[0]) m_led = data[3:0];
            m_count = m_count + 32'd1;
            return 2'b00;
        end else if (off == 2) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (int'(addr[3:2]))
            0:       return {28'd0, m_led};
            1:       return m_count;
            2:       return m_scratch;
            default: return 32'h1ED0_0001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW issued aw_dly cycles in, W issued w_dly cycles in, BREADY after b_dly
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        logic [1:0] exp_resp;
        bit aw_ok, w_ok, a_now, w_now;
        int cyc;
        exp_resp = model_write(addr, data, strb);
        aw_ok = 0; w_ok = 0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 40) begin
            if (cyc == aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (cyc == w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            check_eq({tag, " bvalid_early"}, 32'(bvalid), 32'd0);
            a_now = awvalid && awready;
            w_now = wvalid && wready;
            tick();
            cyc++;
            if (a_now) begin awvalid = 1'b0; aw_ok = 1; end
            if (w_now) begin wvalid = 1'b0; w_ok = 1; end
            if (aw_ok && !w_ok) check_eq({tag, " awready_held"}, 32'(awready), 32'd0);
            if (w_ok && !aw_ok) check_eq({tag, " wready_held"}, 32'(wready), 32'd0);
        end
        if (!(aw_ok && w_ok)) begin
            check_eq({tag, " handshake_timeout"}, 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check_eq({tag, " bvalid"}, 32'(bvalid), 32'd1);
        check_eq({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check_eq({tag, " bvalid_hold"}, 32'(bvalid), 32'd1);
            check_eq({tag, " bresp_hold"}, 32'(bresp), 32'(exp_resp));
            check_eq({tag, " ready_hold"}, {30'd0, awready, wready}, 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq({tag, " bvalid_done"}, 32'(bvalid), 32'd0);
        check_eq({tag, " ready_back"}, {30'd0, awready, wready}, 32'd3);
        check_eq({tag, " leds"}, 32'(leds), 32'(m_led));
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input int r_dly);
        logic [31:0] exp;
        bit hs, hs_now;
        int cyc;
        exp = model_read(addr);
        araddr = addr; arvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 40) begin
            hs_now = arvalid && arready;
            tick();
            cyc++;
            if (hs_now) hs = 1;
        end
        arvalid = 1'b0;
        if (!hs) begin
            check_eq({tag, " ar_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, " rvalid"}, 32'(rvalid), 32'd1);
        check_eq({tag, " rdata"}, rdata, exp);
        check_eq({tag, " rresp"}, 32'(rresp), 32'd0);
        check_eq({tag, " arready_low"}, 32'(arready), 32'd0);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check_eq({tag, " rdata_hold"}, rdata, exp);
            check_eq({tag, " rvalid_hold"}, 32'(rvalid), 32'd1);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_eq({tag, " rvalid_done"}, 32'(rvalid), 32'd0);
        check_eq({tag, " arready_back"}, 32'(arready), 32'd1);
    endtask

    // Write and read launched together; the read must see pre-write contents
    task automatic write_with_read(input string tag, input logic [31:0] waddr,
                                   input logic [31:0] data, input logic [31:0] raddr);
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        exp_rd   = model_read(raddr);
        check_eq({tag, " idle_ready"}, {29'd0, awready, wready, arready}, 32'd7);
        awaddr = waddr; wdata = data; wstrb = 4'hF; araddr = raddr;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        exp_resp = model_write(waddr, data, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq({tag, " bvalid"}, 32'(bvalid), 32'd1);
        check_eq({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
        check_eq({tag, " rvalid"}, 32'(rvalid), 32'd1);
        check_eq({tag, " rdata_old"}, rdata, exp_rd);
        check_eq({tag, " leds"}, 32'(leds), 32'(m_led));
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check_eq({tag, " both_done"}, {30'd0, bvalid, rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base, addr, data;
        logic [1:0]  off;
        logic [3:0]  strb;
        logic [3:0]  pattern [5];

        reset = 1'b1;
        awaddr = '0; awvalid = 0; awprot = '0; wdata = '0; wvalid = 0; wstrb = '0;
        bready = 0; araddr = '0; arvalid = 0; arprot = '0; rready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Reset state and ID register
        check_eq("rst leds", 32'(leds), 32'd0);
        check_eq("rst readies", {29'd0, awready, wready, arready}, 32'd7);
        check_eq("rst valids", {30'd0, bvalid, rvalid}, 32'd0);
        check_eq("rst resp_data", {rdata[29:0], bresp}, 32'd0);
        axi_read("id", 32'h0000_000C, 0);

        // Same-cycle AW/W to LED, then counter
        axi_write("led5", 32'h0, 32'h5, 4'hF, 0, 0, 0);
        axi_read("cnt1", 32'h4, 1);

        // W three cycles ahead of AW, partial strobes, delayed BREADY
        axi_write("scr_beef", 32'h8, 32'hDEAD_BEEF, 4'h3, 3, 0, 4);
        axi_read("scr_rd", 32'h8, 0);

        // Read-only targets answer SLVERR and change nothing
        axi_write("wr_cnt", 32'h4, 32'h1234, 4'hF, 0, 0, 1);
        axi_write("wr_id", 32'hC, 32'h0, 4'hF, 1, 0, 0);
        axi_read("cnt_keep", 32'h4, 0);
        axi_read("id_keep", 32'hC, 0);

        // Strobe-less LED write: OKAY, counts, no data change; AW ahead of W
        axi_write("led_nostrb", 32'h0, 32'hA, 4'h0, 0, 2, 0);
        axi_read("cnt_nostrb", 32'h4, 0);

        // Read and write completing in the same cycle
        write_with_read("sim_cnt", 32'h0, 32'hA, 32'h4);
        write_with_read("sim_led", 32'h10, 32'h3, 32'h20);

        // Reset while both responses are pending
        awaddr = 32'h8; wdata = 32'h55AA_55AA; wstrb = 4'hF; araddr = 32'h0;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check_eq("prerst valids", {30'd0, bvalid, rvalid}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst valids", {30'd0, bvalid, rvalid}, 32'd0);
        check_eq("midrst leds", 32'(leds), 32'd0);
        check_eq("midrst readies", {29'd0, awready, wready, arready}, 32'd7);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        axi_read("postrst led", 32'h0, 0);
        axi_read("postrst cnt", 32'h4, 0);
        axi_read("postrst scr", 32'h8, 0);
        axi_write("postrst wr", 32'h8, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_read("postrst rd", 32'h8, 0);

        // Generator-style LED walk with random response backpressure
        pattern[0] = 4'h1; pattern[1] = 4'h2; pattern[2] = 4'h4; pattern[3] = 4'h8;
        pattern[4] = 4'h0;
        for (int i = 0; i < 5; i++) begin
            axi_write($sformatf("walk%0d", i), 32'h0, 32'(pattern[i]), 4'hF,
                      0, 0, int'($urandom_range(0, 3)));
            check_eq($sformatf("walk%0d led", i), 32'(leds), 32'(pattern[i]));
        end
        axi_read("walk cnt", 32'h4, int'($urandom_range(0, 3)));
        check_eq("walk cnt5", rdata, 32'd5);

        // Random mix with aliased addresses and random strobes/delays
        for (int t = 0; t < 80; t++) begin
            base = $urandom;
            off  = 2'($urandom_range(0, 3));
            addr = {base[31:4], off, base[1:0]};
            if ($urandom_range(0, 2) == 0) begin
                axi_read($sformatf("rnd%0d rd", t), addr, int'($urandom_range(0, 3)));
            end else begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write($sformatf("rnd%0d wr", t), addr, data, strb,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
            end
        end
        axi_read("final cnt", 32'h4, 0);
        axi_read("final scr", 32'h8, 0);
        axi_read("final led", 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
